// File: rtl/ras_ckpt_ctrl_pkg.sv
// Shared types for the RAS front-end: RAS entry, opcodes, RAS command and checkpoint layout.
// Also holds the FSM state type used by ras_ckpt_ctrl.
package ras_ckpt_ctrl_pkg;

  localparam int RAS_DEPTH_DEF = 32;
  localparam int RAS_PW        = $clog2(RAS_DEPTH_DEF);

  localparam logic [4:0] LINK_X1 = 5'd1;
  localparam logic [4:0] LINK_X5 = 5'd5;

  typedef enum logic [6:0] {
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ras_t;

  typedef enum logic [1:0] {
    RAS_NONE = 2'd0,
    RAS_PUSH = 2'd1,
    RAS_POP  = 2'd2
  } ras_op_e;

  // RAS state seen before the instruction's own op, plus that op and its link address.
  typedef struct packed {
    logic [RAS_PW-1:0] ptr;
    ras_t              top;
    ras_op_e           op;
    logic [31:0]       link_pc;
  } ras_ckpt_t;

  typedef enum logic {
    ST_IDLE        = 1'b0,
    ST_RECOVER_POP = 1'b1
  } ckpt_state_e;

  function automatic logic is_link(input logic [4:0] r);
    return (r == LINK_X1) || (r == LINK_X5);
  endfunction

endpackage

// File: rtl/ras_ckpt_ctrl_callret_decode.sv
// Combinational call/return classifier: instruction word -> control-flow flag and RAS op.
// Module name ras_callret_decode.
module ras_callret_decode
  import ras_ckpt_ctrl_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic        o_is_cf,
  output ras_op_e     o_op
);

  logic [6:0] w_opc;
  logic [4:0] w_rd;
  logic [4:0] w_rs1;
  logic [2:0] w_funct3;
  logic       w_unused;

  assign w_opc    = i_instr[6:0];
  assign w_rd     = i_instr[11:7];
  assign w_funct3 = i_instr[14:12];
  assign w_rs1    = i_instr[19:15];
  assign w_unused = ^i_instr[31:20];

  always_comb begin
    o_is_cf = 1'b0;
    o_op    = RAS_NONE;
    case (w_opc)
      OPC_JAL: begin
        o_is_cf = 1'b1;
        if (is_link(w_rd)) o_op = RAS_PUSH;
      end
      OPC_JALR: begin
        if (w_funct3 == 3'b000) begin
          o_is_cf = 1'b1;
          // A link rd wins even when rs1 is also a link register (coroutine swap treated as call).
          if (is_link(w_rd))       o_op = RAS_PUSH;
          else if (is_link(w_rs1)) o_op = RAS_POP;
        end
      end
      OPC_BRANCH: o_is_cf = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/ras_ckpt_ctrl.sv
// RAS driver and checkpoint FIFO: issues push/pop, predicts returns, restores RAS on mispredict.
// Optional statistics counters enabled by defining RAS_CKPT_STATS_EN.
//   state          | meaning
//   ST_IDLE        | normal fetch decode
//   ST_RECOVER_POP | re-apply the squashed return's pop, fetch held
module ras_ckpt_ctrl
  import ras_ckpt_ctrl_pkg::*;
#(
  parameter  int NUM_CKPT  = 8,
  parameter  int RAS_DEPTH = RAS_DEPTH_DEF,
  localparam int CW        = $clog2(NUM_CKPT),
  localparam int PW        = $clog2(RAS_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_fetch_valid,
  input  logic [31:0]   i_fetch_instr,
  input  logic [31:0]   i_fetch_pc,
  output logic          o_fetch_ready,
  output logic [CW-1:0] o_fetch_ckpt_tag,
  output logic          o_pred_ret_valid,
  output logic [31:0]   o_pred_ret_target,
  output logic          o_ras_push,
  output logic          o_ras_pop,
  output ras_t          o_ras_din,
  input  ras_t          i_ras_dout,
  input  logic [PW-1:0] i_ras_stack_ptr,
  input  logic          i_cdb_br_valid,
  input  logic          i_cdb_br_mispred,
  input  logic [CW-1:0] i_cdb_br_tag,
  input  logic          i_commit_valid,
  output ras_t          o_br_ras_top,
  output logic [PW-1:0] o_br_stack_ptr_val
`ifdef RAS_CKPT_STATS_EN
  ,
  output logic [31:0]   o_stat_recover_cnt,
  output logic [31:0]   o_stat_full_stall_cnt
`endif
);

  localparam logic [CW:0] FULL_CNT = NUM_CKPT[CW:0];

  logic [CW:0] r_head, r_tail;
  ckpt_state_e r_state, w_state_nxt;
  ras_ckpt_t   r_ckpt [NUM_CKPT];

  logic        w_is_cf, w_full, w_mispred, w_accept, w_alloc;
  ras_op_e     w_op;
  logic [CW:0] w_count, w_tag_full;
  ras_ckpt_t   w_rd_entry;

  ras_callret_decode u_decode (
    .i_instr (i_fetch_instr),
    .o_is_cf (w_is_cf),
    .o_op    (w_op)
  );

  assign w_mispred  = i_cdb_br_valid & i_cdb_br_mispred;
  assign w_count    = r_tail - r_head;
  assign w_full     = (w_count == FULL_CNT);
  assign w_rd_entry = r_ckpt[i_cdb_br_tag];
  // Rebuild the wrap bit of the resolved tag: below head's index means it lives in the next lap.
  assign w_tag_full = {r_head[CW] ^ (i_cdb_br_tag < r_head[CW-1:0]), i_cdb_br_tag};

  assign o_fetch_ready = (r_state == ST_IDLE) & ~w_mispred & ~(w_is_cf & w_full);
  assign w_accept      = i_fetch_valid & o_fetch_ready;
  assign w_alloc       = w_accept & w_is_cf;

  always_comb begin
    o_ras_push         = 1'b0;
    o_ras_pop          = 1'b0;
    o_ras_din          = '0;
    o_fetch_ckpt_tag   = '0;
    o_pred_ret_valid   = 1'b0;
    o_pred_ret_target  = '0;
    o_br_ras_top       = '0;
    o_br_stack_ptr_val = '0;
    w_state_nxt        = r_state;
    if (w_mispred) begin
      o_br_stack_ptr_val = w_rd_entry.ptr;
      o_br_ras_top       = w_rd_entry.top;
      w_state_nxt        = ST_IDLE;
      case (w_rd_entry.op)
        RAS_PUSH: begin
          o_br_stack_ptr_val = w_rd_entry.ptr + 1'b1;
          o_br_ras_top       = '{valid: 1'b1, addr: w_rd_entry.link_pc};
        end
        RAS_POP: w_state_nxt = ST_RECOVER_POP;
        default: ;
      endcase
    end else if (r_state == ST_RECOVER_POP) begin
      o_ras_pop   = 1'b1;
      w_state_nxt = ST_IDLE;
    end else if (w_accept) begin
      o_ras_push = (w_op == RAS_PUSH);
      o_ras_pop  = (w_op == RAS_POP);
      if (w_op == RAS_PUSH) o_ras_din = '{valid: 1'b1, addr: i_fetch_pc + 32'd4};
      if (w_is_cf) o_fetch_ckpt_tag = r_tail[CW-1:0];
      if ((w_op == RAS_POP) && i_ras_dout.valid) begin
        o_pred_ret_valid  = 1'b1;
        o_pred_ret_target = i_ras_dout.addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (i_commit_valid) r_head <= r_head + 1'b1;
      if (w_mispred)    r_tail <= w_tag_full + 1'b1;
      else if (w_alloc) r_tail <= r_tail + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_alloc)
      r_ckpt[r_tail[CW-1:0]] <= '{ptr: i_ras_stack_ptr, top: i_ras_dout, op: w_op,
                                  link_pc: i_fetch_pc + 32'd4};
  end

  a_tag_in_flight: assert property (@(posedge clk) disable iff (rst)
    w_mispred |-> ((w_tag_full - r_head) < w_count));

`ifdef RAS_CKPT_STATS_EN
  logic [31:0] r_stat_recover_cnt, r_stat_full_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_recover_cnt    <= '0;
      r_stat_full_stall_cnt <= '0;
    end else begin
      if (w_mispred && (r_stat_recover_cnt != '1))
        r_stat_recover_cnt <= r_stat_recover_cnt + 1'b1;
      if (i_fetch_valid && w_is_cf && w_full && (r_stat_full_stall_cnt != '1))
        r_stat_full_stall_cnt <= r_stat_full_stall_cnt + 1'b1;
    end
  end

  assign o_stat_recover_cnt    = r_stat_recover_cnt;
  assign o_stat_full_stall_cnt = r_stat_full_stall_cnt;
`else
  // Statistics counters not built.
`endif

endmodule
